vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter HRES, default 1600: active pixels per line.
REQ-002 Parameter VRES, default 900: active lines per frame.
REQ-003 Parameters HFP/HSW/HBP, defaults 24/80/96: horizontal front porch, sync width and back porch, in pixels.
REQ-004 Parameters VFP/VSW/VBP, defaults 1/3/96: vertical front porch, sync width and back porch, in lines.
REQ-005 Parameters HS_POL/VS_POL, default 1/1: asserted level of vga_hs_o/vga_vs_o.
REQ-006 clk  input  1  pixel clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  pixel advance enable; the counters advance only on cycles with en=1.
REQ-009 h_cnt  output  11  current column, 0..HTOT-1.
REQ-010 v_cnt  output  11  current row, 0..VTOT-1.
REQ-011 vga_dv_o  output  1  active-video (data valid) for the current (h_cnt,v_cnt).
REQ-012 vga_hs_o  output  1  horizontal sync at HS_POL level when asserted.
REQ-013 vga_vs_o  output  1  vertical sync at VS_POL level when asserted.
REQ-014 sof_o  output  1  start-of-frame, high while (h_cnt,v_cnt)=(0,0) after an advance.
REQ-015 eol_o  output  1  end-of-active-line, high while h_cnt=HRES-1 and v_cnt<VRES.

Function
REQ-016 Define HTOT=HRES+HFP+HSW+HBP (default 1800) and VTOT=VRES+VFP+VSW+VBP (default 1000); both SHALL be <=2048, enforced by an elaboration-time check.
REQ-017 On an en=1 cycle, h_cnt SHALL increment, wrapping from HTOT-1 to 0.
REQ-018 v_cnt SHALL increment only when h_cnt wraps, wrapping from VTOT-1 to 0 in the same cycle that h_cnt wraps.
REQ-019 When en=0, the counters and all outputs SHALL hold their values.
REQ-020 All outputs SHALL be registered and consistent with the h_cnt/v_cnt values registered in the same cycle (zero relative skew).
REQ-021 vga_dv_o SHALL be 1 iff h_cnt<HRES and v_cnt<VRES.
REQ-022 vga_hs_o SHALL equal HS_POL iff HRES+HFP <= h_cnt < HRES+HFP+HSW, and !HS_POL otherwise.
REQ-023 vga_vs_o SHALL equal VS_POL iff VRES+VFP <= v_cnt < VRES+VFP+VSW, and !VS_POL otherwise; it is decoded on v_cnt only, so it changes at h_cnt=0.
REQ-024 sof_o SHALL be high for exactly one advance per frame.
REQ-025 eol_o SHALL be high for exactly one advance per active line and is never high during vertical blanking.
REQ-026 The counter decode SHALL be implemented as an explicit two-level scan, with the horizontal phase (ACTIVE, FP, SYNC, BP) and the vertical phase tracked as state.
REQ-027 The outputs SHALL be identical to the decode in REQ-021..025.

Reset
REQ-028 While rst=0, the block SHALL hold h_cnt=HTOT-1, v_cnt=VTOT-1, vga_dv_o=0, vga_hs_o=!HS_POL, vga_vs_o=!VS_POL, sof_o=0 and eol_o=0.
REQ-029 The first en=1 cycle after rst deasserts SHALL produce (h_cnt,v_cnt)=(0,0), vga_dv_o=1 and sof_o=1.
REQ-030 Reset asserted mid-frame SHALL take effect immediately (asynchronously), with no partial-frame recovery.

Verification
REQ-031 Release reset with en=1 held high: first cycle (0,0), dv=1, sof=1; h_cnt=1599 gives dv=1, eol=1; h_cnt=1600 gives dv=0.
REQ-032 Run one full frame with en=1: exactly 1,800,000 advances between sof pulses; dv high count 1,440,000; eol count 900; hs pulses 1000, each 80 cycles wide starting at h_cnt=1624; vs high for v_cnt 901..903 (5400 cycles).
REQ-033 Boundary wrap: at (1799,999) -> next (0,0) with sof=1; at (1799,5) -> next (0,6).
REQ-034 en toggled pseudo-randomly at 50%: counter sequence and outputs identical to REQ-032 when sampled only on en=1 cycles; all outputs stable while en=0.
REQ-035 Assert rst at (700,450) with dv=1: outputs go to the REQ-028 values without waiting for a clock edge; after release, frame restarts at (0,0).
REQ-036 HS_POL=0, VS_POL=0 build: idle sync outputs read 1, sync pulses read 0, and timing is unchanged from REQ-032.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Interface carrying the video-timing bundle between the timing generator
// (master) and whatever consumes the raster position and syncs (slave).
interface vga_timing_gen_if;
    logic        en;
    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        vga_dv_o;
    logic        vga_hs_o;
    logic        vga_vs_o;
    logic        sof_o;
    logic        eol_o;

    modport master (
        input  en,
        output h_cnt, v_cnt, vga_dv_o, vga_hs_o, vga_vs_o, sof_o, eol_o
    );

    modport slave (
        output en,
        input  h_cnt, v_cnt, vga_dv_o, vga_hs_o, vga_vs_o, sof_o, eol_o
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. A two-level scan walks the horizontal phases
// (ACTIVE, FP, SYNC, BP) inside each line and the vertical phases inside each
// frame. All outputs are registered from the same next-state values as the
// counters, so they never skew against h_cnt/v_cnt.
module vga_timing_gen #(
    parameter int HRES   = 1600,
    parameter int VRES   = 900,
    parameter int HFP    = 24,
    parameter int HSW    = 80,
    parameter int HBP    = 96,
    parameter int VFP    = 1,
    parameter int VSW    = 3,
    parameter int VBP    = 96,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    vga_timing_gen_if.master   vga
);

    localparam int HTOT = HRES + HFP + HSW + HBP;
    localparam int VTOT = VRES + VFP + VSW + VBP;

    // Counters are 11 bits wide, so neither total may exceed 2048.
    generate
        if (HTOT > 2048 || VTOT > 2048) begin : g_rangeCheck
            $error("vga_timing_gen: HTOT (%0d) and VTOT (%0d) must be <= 2048", HTOT, VTOT);
        end
    endgenerate

    localparam logic [10:0] H_LAST       = 11'(HTOT - 1);
    localparam logic [10:0] H_EOL        = 11'(HRES - 1);
    localparam logic [10:0] H_FP_START   = 11'(HRES);
    localparam logic [10:0] H_SYNC_START = 11'(HRES + HFP);
    localparam logic [10:0] H_BP_START   = 11'(HRES + HFP + HSW);
    localparam logic [10:0] V_LAST       = 11'(VTOT - 1);
    localparam logic [10:0] V_FP_START   = 11'(VRES);
    localparam logic [10:0] V_SYNC_START = 11'(VRES + VFP);
    localparam logic [10:0] V_BP_START   = 11'(VRES + VFP + VSW);

    typedef enum logic [1:0] {H_ACTIVE, H_FP, H_SYNC, H_BP} hPhase_t;
    typedef enum logic [1:0] {V_ACTIVE, V_FP, V_SYNC, V_BP} vPhase_t;

    logic [10:0] r_hCnt;
    logic [10:0] r_vCnt;
    hPhase_t     r_hPhase;
    vPhase_t     r_vPhase;
    logic        r_dv;
    logic        r_hs;
    logic        r_vs;
    logic        r_sof;
    logic        r_eol;

    logic        w_hWrap;
    logic [10:0] w_hNext;
    logic [10:0] w_vNext;
    hPhase_t     w_hPhaseNext;
    vPhase_t     w_vPhaseNext;
    logic        w_dvNext;
    logic        w_hsNext;
    logic        w_vsNext;
    logic        w_sofNext;
    logic        w_eolNext;

    // Next scan position, next phases and the output decode of that position.
    // Zero-width porches/syncs are skipped by checking later phases first.
    always_comb begin
        w_hWrap      = (r_hCnt == H_LAST);
        w_hNext      = w_hWrap ? 11'd0 : r_hCnt + 11'd1;
        w_vNext      = r_vCnt;
        w_hPhaseNext = r_hPhase;
        w_vPhaseNext = r_vPhase;

        if (w_hNext == 11'd0)
            w_hPhaseNext = H_ACTIVE;
        else if ((HBP > 0) && (w_hNext == H_BP_START))
            w_hPhaseNext = H_BP;
        else if ((HSW > 0) && (w_hNext == H_SYNC_START))
            w_hPhaseNext = H_SYNC;
        else if ((HFP > 0) && (w_hNext == H_FP_START))
            w_hPhaseNext = H_FP;

        if (w_hWrap) begin
            w_vNext = (r_vCnt == V_LAST) ? 11'd0 : r_vCnt + 11'd1;
            if (w_vNext == 11'd0)
                w_vPhaseNext = V_ACTIVE;
            else if ((VBP > 0) && (w_vNext == V_BP_START))
                w_vPhaseNext = V_BP;
            else if ((VSW > 0) && (w_vNext == V_SYNC_START))
                w_vPhaseNext = V_SYNC;
            else if ((VFP > 0) && (w_vNext == V_FP_START))
                w_vPhaseNext = V_FP;
        end

        w_dvNext  = (w_hPhaseNext == H_ACTIVE) && (w_vPhaseNext == V_ACTIVE);
        w_hsNext  = (w_hPhaseNext == H_SYNC) ? HS_POL : !HS_POL;
        w_vsNext  = (w_vPhaseNext == V_SYNC) ? VS_POL : !VS_POL;
        w_sofNext = (w_hNext == 11'd0) && (w_vNext == 11'd0);
        w_eolNext = (w_hNext == H_EOL) && (w_vPhaseNext == V_ACTIVE);
    end

    // Scan state and registered outputs; reset parks the scan on the last
    // pixel of the frame so the first advance lands on (0,0). The reset phase
    // value only has to be "not ACTIVE" since the first advance reloads it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hCnt   <= H_LAST;
            r_vCnt   <= V_LAST;
            r_hPhase <= H_BP;
            r_vPhase <= V_BP;
            r_dv     <= 1'b0;
            r_hs     <= !HS_POL;
            r_vs     <= !VS_POL;
            r_sof    <= 1'b0;
            r_eol    <= 1'b0;
        end else if (vga.en) begin
            r_hCnt   <= w_hNext;
            r_vCnt   <= w_vNext;
            r_hPhase <= w_hPhaseNext;
            r_vPhase <= w_vPhaseNext;
            r_dv     <= w_dvNext;
            r_hs     <= w_hsNext;
            r_vs     <= w_vsNext;
            r_sof    <= w_sofNext;
            r_eol    <= w_eolNext;
        end
    end

    assign vga.h_cnt    = r_hCnt;
    assign vga.v_cnt    = r_vCnt;
    assign vga.vga_dv_o = r_dv;
    assign vga.vga_hs_o = r_hs;
    assign vga.vga_vs_o = r_vs;
    assign vga.sof_o    = r_sof;
    assign vga.eol_o    = r_eol;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: two small-raster instances (positive and
// negative sync polarity) driven by shared clk/rst/en, compared every cycle
// against a closed-form model of the raster position.
module tb_vga_timing_gen;

    localparam int HRES  = 16;
    localparam int VRES  = 8;
    localparam int HFP   = 2;
    localparam int HSW   = 3;
    localparam int HBP   = 4;
    localparam int VFP   = 1;
    localparam int VSW   = 2;
    localparam int VBP   = 2;
    localparam int HTOT  = HRES + HFP + HSW + HBP;
    localparam int VTOT  = VRES + VFP + VSW + VBP;
    localparam int FRAME = HTOT * VTOT;

    logic clk = 1'b0;
    logic rstN;
    logic enDrive;

    int checkCount;
    int errorCount;
    int advCount;
    int statDv, statEol, statHs, statVs, statSof, statHsLow1, hsPulses;
    logic prevHs;

    vga_timing_gen_if vgaIf0 ();
    vga_timing_gen_if vgaIf1 ();

    assign vgaIf0.en = enDrive;
    assign vgaIf1.en = enDrive;

    vga_timing_gen #(
        .HRES(HRES), .VRES(VRES), .HFP(HFP), .HSW(HSW), .HBP(HBP),
        .VFP(VFP), .VSW(VSW), .VBP(VBP), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dutPos (
        .clk (clk),
        .rst (rstN),
        .vga (vgaIf0)
    );

    vga_timing_gen #(
        .HRES(HRES), .VRES(VRES), .HFP(HFP), .HSW(HSW), .HBP(HBP),
        .VFP(VFP), .VSW(VSW), .VBP(VBP), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dutNeg (
        .clk (clk),
        .rst (rstN),
        .vga (vgaIf1)
    );

    // Free-running pixel clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Expected raster state from the number of advances since reset:
    // advance n (n>=1) shows linear position n-1 within the frame.
    task automatic checkAll(input string phase);
        int p, h, v;
        bit dv, hsAct, vsAct, sof, eol;
        if (advCount == 0) begin
            h = HTOT - 1; v = VTOT - 1;
            dv = 0; hsAct = 0; vsAct = 0; sof = 0; eol = 0;
        end else begin
            p     = (advCount - 1) % FRAME;
            h     = p % HTOT;
            v     = p / HTOT;
            dv    = (h < HRES) && (v < VRES);
            hsAct = (h >= HRES + HFP) && (h < HRES + HFP + HSW);
            vsAct = (v >= VRES + VFP) && (v < VRES + VFP + VSW);
            sof   = (h == 0) && (v == 0);
            eol   = (h == HRES - 1) && (v < VRES);
        end
        checkOutput({phase, " pos h_cnt"}, int'(vgaIf0.h_cnt),    h);
        checkOutput({phase, " pos v_cnt"}, int'(vgaIf0.v_cnt),    v);
        checkOutput({phase, " pos dv"},    int'(vgaIf0.vga_dv_o), int'(dv));
        checkOutput({phase, " pos hs"},    int'(vgaIf0.vga_hs_o), int'(hsAct));
        checkOutput({phase, " pos vs"},    int'(vgaIf0.vga_vs_o), int'(vsAct));
        checkOutput({phase, " pos sof"},   int'(vgaIf0.sof_o),    int'(sof));
        checkOutput({phase, " pos eol"},   int'(vgaIf0.eol_o),    int'(eol));
        checkOutput({phase, " neg h_cnt"}, int'(vgaIf1.h_cnt),    h);
        checkOutput({phase, " neg v_cnt"}, int'(vgaIf1.v_cnt),    v);
        checkOutput({phase, " neg dv"},    int'(vgaIf1.vga_dv_o), int'(dv));
        checkOutput({phase, " neg hs"},    int'(vgaIf1.vga_hs_o), int'(!hsAct));
        checkOutput({phase, " neg vs"},    int'(vgaIf1.vga_vs_o), int'(!vsAct));
        checkOutput({phase, " neg sof"},   int'(vgaIf1.sof_o),    int'(sof));
        checkOutput({phase, " neg eol"},   int'(vgaIf1.eol_o),    int'(eol));
    endtask

    task automatic clearStats();
        statDv = 0; statEol = 0; statHs = 0; statVs = 0;
        statSof = 0; statHsLow1 = 0; hsPulses = 0;
        prevHs = vgaIf0.vga_hs_o;
    endtask

    // Drive en on the falling edge (0: always on, 1: random 50%, 2: off),
    // sample just after the rising edge, advance the model and check.
    task automatic applyStimulus(input int cycles, input int enMode);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            case (enMode)
                0:       enDrive = 1'b1;
                1:       enDrive = 1'($urandom_range(1, 0));
                default: enDrive = 1'b0;
            endcase
            @(posedge clk);
            #1;
            if (rstN && enDrive) begin
                advCount++;
                statDv     += int'(vgaIf0.vga_dv_o);
                statEol    += int'(vgaIf0.eol_o);
                statHs     += int'(vgaIf0.vga_hs_o);
                statVs     += int'(vgaIf0.vga_vs_o);
                statSof    += int'(vgaIf0.sof_o);
                statHsLow1 += int'(!vgaIf1.vga_hs_o);
                if (vgaIf0.vga_hs_o && !prevHs) hsPulses++;
                prevHs = vgaIf0.vga_hs_o;
            end
            checkAll("run");
        end
    endtask

    // Main sequence
    initial begin
        int target;
        int waited;
        checkCount = 0;
        errorCount = 0;
        advCount   = 0;
        rstN       = 1'b0;
        enDrive    = 1'b0;
        clearStats();

        $display("[TB] reset hold with random en");
        applyStimulus(6, 1);

        $display("[TB] release reset, one full frame with en high");
        rstN = 1'b1;
        clearStats();
        applyStimulus(FRAME, 0);
        checkOutput("frame sof count",   statSof,    1);
        checkOutput("frame dv count",    statDv,     HRES * VRES);
        checkOutput("frame eol count",   statEol,    VRES);
        checkOutput("frame hs cycles",   statHs,     VTOT * HSW);
        checkOutput("frame hs pulses",   hsPulses,   VTOT);
        checkOutput("frame vs cycles",   statVs,     VSW * HTOT);
        checkOutput("frame neg hs low",  statHsLow1, VTOT * HSW);

        $display("[TB] frame wrap");
        applyStimulus(1, 0);

        $display("[TB] random en for several frames");
        applyStimulus(3 * FRAME, 1);

        $display("[TB] asynchronous reset mid-frame");
        target = 4 * HTOT + 7;
        waited = 0;
        while ((((advCount - 1) % FRAME) != target) && (waited < 2 * FRAME)) begin
            applyStimulus(1, 0);
            waited++;
        end
        checkOutput("reach reset point", int'(((advCount - 1) % FRAME) == target), 1);
        checkOutput("pre-reset dv", int'(vgaIf0.vga_dv_o), 1);
        @(negedge clk);
        #2;
        rstN     = 1'b0;
        advCount = 0;
        #1;
        checkAll("async reset");
        applyStimulus(3, 1);
        rstN = 1'b1;
        applyStimulus(2 * HTOT + 3, 0);
        applyStimulus(FRAME, 1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
